// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel scan-out path: buffer geometry,
// RGB pixel type and the power-on 16-colour palette.
package pixel_pkg;

  localparam int RAM_LATENCY     = 3;
  localparam int PIXEL_ADDR_BITS = 11;
  localparam int PAL_ENTRIES     = 16;

  typedef logic [23:0] rgb_t;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

  // Standard terminal colours, R[23:16] G[15:8] B[7:0].
  localparam rgb_t DEFAULT_PALETTE [PAL_ENTRIES] = '{
    24'h000000, 24'hAA0000, 24'h00AA00, 24'hAA5500,
    24'h0000AA, 24'hAA00AA, 24'h00AAAA, 24'hAAAAAA,
    24'h555555, 24'hFF5555, 24'h55FF55, 24'hFFFF55,
    24'h5555FF, 24'hFF55FF, 24'h55FFFF, 24'hFFFFFF
  };

endpackage

// File: rtl/pixel_scanout_sync_delay.sv
// N-stage shift register carrying {de, hsync, vsync} alongside the pixel
// pipeline; a synchronous clear empties every stage at once.
module sync_delay
  import pixel_pkg::*;
#(
  parameter int N = 4
) (
  input  logic  clk,
  input  logic  clr_i,
  input  sync_t d_i,
  output sync_t q_o
);

  sync_t stage_q [N];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its
      // predecessor's old value, so the chain shifts by exactly one per edge.
      stage_q[0] <= d_i;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/pixel_scanout.sv
// Scans one half of the pixel line buffer per video line, colours each index
// through a writable palette and re-aligns the syncs with the coloured pixel.
module pixel_scanout
  import pixel_pkg::*;
#(
  parameter int LINE_WIDTH  = 1024,
  parameter int X_BITS      = 10,
  parameter int RAM_LATENCY = pixel_pkg::RAM_LATENCY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       de_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  output logic [PIXEL_ADDR_BITS-1:0] rd_addr,
  input  logic [3:0]                 rd_pixel,
  input  logic                       pal_we,
  input  logic [3:0]                 pal_index,
  input  logic [23:0]                pal_rgb,
  output logic [23:0]                rgb_out,
  output logic                       de_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       line_free,
  output logic                       line_free_sel
);

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(LINE_WIDTH - 1);

  logic [X_BITS-1:0]          x_q, x_d;
  logic                       line_sel_q, line_sel_d;
  logic                       de_prev_q, vs_prev_q;
  logic [PIXEL_ADDR_BITS-1:0] rd_addr_q;
  logic                       line_free_q, line_free_sel_q;
  rgb_t                       rgb_q;
  sync_t                      sync_out_q;
  rgb_t                       pal_q [PAL_ENTRIES];

  logic  de_fall, vs_rise;
  sync_t sync_in, sync_tap;

  assign de_fall = de_prev_q & ~de_in;
  assign vs_rise = vsync_in & ~vs_prev_q;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred when none of the branches below fires.
    x_d        = x_q;
    line_sel_d = line_sel_q;
    if (vs_rise) begin
      x_d        = '0;
      line_sel_d = 1'b0;
    end else if (de_fall) begin
      x_d        = '0;
      line_sel_d = ~line_sel_q;
    end else if (de_in && (x_q != X_MAX)) begin
      x_d = x_q + 1'b1;
    end
  end

  // The tap sits one stage short of the full delay: it qualifies the palette
  // lookup, and the final stage is the output register below.
  assign sync_in = '{de: de_in, hsync: hsync_in, vsync: vsync_in};

  sync_delay #(.N(RAM_LATENCY + 1)) u_sync_delay (
    .clk   (clk),
    .clr_i (reset),
    .d_i   (sync_in),
    .q_o   (sync_tap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q             <= '0;
      line_sel_q      <= 1'b0;
      de_prev_q       <= 1'b0;
      vs_prev_q       <= 1'b0;
      rd_addr_q       <= '0;
      line_free_q     <= 1'b0;
      line_free_sel_q <= 1'b0;
      rgb_q           <= '0;
      sync_out_q      <= '0;
    end else begin
      x_q         <= x_d;
      line_sel_q  <= line_sel_d;
      de_prev_q   <= de_in;
      vs_prev_q   <= vsync_in;
      rd_addr_q   <= {line_sel_q, x_q};
      line_free_q <= de_fall;
      if (de_fall) line_free_sel_q <= line_sel_q;
      rgb_q       <= sync_tap.de ? pal_q[rd_pixel] : '0;
      sync_out_q  <= sync_tap;
    end
  end

  // A write lands at the edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the palette is a small register file, not a RAM, so it can and
      // must be reset to the default colours.
      for (int i = 0; i < PAL_ENTRIES; i++) pal_q[i] <= DEFAULT_PALETTE[i];
    end else if (pal_we) begin
      pal_q[pal_index] <= pal_rgb;
    end
  end

  assign rd_addr       = rd_addr_q;
  assign rgb_out       = rgb_q;
  assign de_out        = sync_out_q.de;
  assign hsync_out     = sync_out_q.hsync;
  assign vsync_out     = sync_out_q.vsync;
  assign line_free     = line_free_q;
  assign line_free_sel = line_free_sel_q;

endmodule

// File: tb/tb_pixel_scanout.sv
// Directed video-line sequences with random buffer contents and palette
// writes, checked every cycle against a line/frame-counting reference model.
module tb_pixel_scanout;
  import pixel_pkg::*;

  localparam int LINE_W = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [10:0] rd_addr;
  logic [3:0]  rd_pixel = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_index = '0;
  logic [23:0] pal_rgb = '0;
  logic [23:0] rgb_out;
  logic        de_out, hsync_out, vsync_out, line_free, line_free_sel;

  pixel_scanout dut (
    .clk           (clk),
    .reset         (reset),
    .de_in         (de_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .rd_addr       (rd_addr),
    .rd_pixel      (rd_pixel),
    .pal_we        (pal_we),
    .pal_index     (pal_index),
    .pal_rgb       (pal_rgb),
    .rgb_out       (rgb_out),
    .de_out        (de_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .line_free     (line_free),
    .line_free_sel (line_free_sel)
  );

  always #5 clk = ~clk;

  // Line buffer read port: 3 cycles from address to data.
  logic [3:0]  mem [2048];
  logic [10:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    a1       <= rd_addr;
    a2       <= a1;
    rd_pixel <= mem[a2];
  end

  int passed = 0, total = 0;
  int t = 0, last_rst = 0;
  int lines = 0, pix = 0;
  logic de_h [16], hs_h [16], vs_h [16];
  int   addr_h [16];
  rgb_t pal_m [16];
  logic e_lfs = 1'b0;
  bit   rand_pal = 0, track_max = 0;
  int   max_addr = 0, lf_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, t);
  endtask

  task automatic fill_mem(input bit random, input logic [3:0] val);
    for (int i = 0; i < 2048; i++) mem[i] = random ? 4'($urandom) : val;
  endtask

  // One clock: drive inputs, take the edge, predict and compare all outputs.
  task automatic step(input logic de, input logic hs, input logic vs, input logic rst,
                      input logic we, input logic [3:0] idx, input logic [23:0] wd);
    int   e_addr, k;
    logic p_de, p_vs, fall, rise, e_lf, e_de, e_hs, e_vs;
    rgb_t e_rgb;
    de_in = de; hsync_in = hs; vsync_in = vs; reset = rst;
    pal_we = we; pal_index = idx; pal_rgb = wd;
    @(posedge clk);
    #1;
    t++;
    e_de = 0; e_hs = 0; e_vs = 0; e_rgb = '0; e_lf = 0; e_addr = 0;
    if (rst) begin
      last_rst = t; lines = 0; pix = 0; e_lfs = 0;
      for (int i = 0; i < 16; i++) pal_m[i] = DEFAULT_PALETTE[i];
    end else begin
      p_de   = (t - 1 > last_rst) ? de_h[(t-1) % 16] : 1'b0;
      p_vs   = (t - 1 > last_rst) ? vs_h[(t-1) % 16] : 1'b0;
      fall   = p_de && !de;
      rise   = vs && !p_vs;
      e_addr = (lines % 2) * LINE_W + pix;
      e_lf   = fall;
      if (fall) e_lfs = 1'((lines % 2));
      if (rise) begin
        lines = 0; pix = 0;
      end else if (fall) begin
        lines++; pix = 0;
      end else if (de && pix < LINE_W - 1) begin
        pix++;
      end
      k = t - 4;
      if (k > last_rst) begin
        e_de = de_h[k % 16]; e_hs = hs_h[k % 16]; e_vs = vs_h[k % 16];
        if (e_de) e_rgb = pal_m[mem[addr_h[k % 16]]];
      end
      if (we) pal_m[idx] = wd;
    end
    de_h[t % 16]   = rst ? 1'b0 : de;
    hs_h[t % 16]   = rst ? 1'b0 : hs;
    vs_h[t % 16]   = rst ? 1'b0 : vs;
    addr_h[t % 16] = e_addr;
    if (track_max && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    if (line_free) lf_count++;
    check("rd_addr", 32'(rd_addr), 32'(e_addr));
    check("rgb_out", 32'(rgb_out), 32'(e_rgb));
    check("de_out", 32'(de_out), 32'(e_de));
    check("hsync_out", 32'(hsync_out), 32'(e_hs));
    check("vsync_out", 32'(vsync_out), 32'(e_vs));
    check("line_free", 32'(line_free), 32'(e_lf));
    if (e_lf || rst) check("line_free_sel", 32'(line_free_sel), 32'(e_lfs));
  endtask

  task automatic active(input int npix);
    logic we;
    for (int i = 0; i < npix; i++) begin
      we = rand_pal && ($urandom_range(0, 31) == 0);
      step(1, 0, 0, 0, we, 4'($urandom), 24'($urandom));
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(0, (i >= 2 && i < 5), 0, 0, 0, 0, 0);
  endtask

  task automatic line(input int npix, input int nblank);
    active(npix);
    blank(nblank);
  endtask

  task automatic frame_start();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    fill_mem(1, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);

    // Short line in half 0, then a 640-pixel line followed by half 1.
    line(8, 10);
    frame_start();
    lf_count = 0;
    line(640, $urandom_range(6, 12));
    line(8, 10);
    check("line_free_pulses", 32'(lf_count), 32'd2);

    // Overlong line in half 0 must saturate at 0x3FF.
    frame_start();
    max_addr = 0;
    track_max = 1;
    active(1100);
    track_max = 0;
    check("sat_max_addr", 32'(max_addr), 32'h3FF);
    blank(10);

    // Palette write racing a lookup of the same index.
    fill_mem(0, 4'd5);
    blank(6);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, (i == 10), 4'd5, 24'h123456);
    blank(8);
    line(8, 10);

    // Frame start while half 1 is selected, then de fall coinciding with vsync rise.
    fill_mem(1, 0);
    blank(6);
    frame_start();
    line(16, 8);
    frame_start();
    line(16, 8);
    active(16);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    blank(8);
    line(8, 8);

    // Reset in the middle of a line.
    active(300);
    step(1, 0, 0, 1, 0, 0, 0);
    blank(8);
    line(8, 8);

    // Random line lengths with random palette traffic.
    rand_pal = 1;
    for (int n = 0; n < 4; n++) line($urandom_range(1, 1200), $urandom_range(6, 20));
    rand_pal = 0;
    blank(8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
